// File: rtl/vga_fetch_arbiter.sv
// vga_fetch_arbiter
//   Shares one single-port framebuffer memory between the display line
//   prefetcher and a host word writer. At hcounter==HLINES it schedules a
//   burst read of the next visible line into a ping-pong line buffer. Host
//   writes are served one word per grant between bursts. The fetch always
//   has priority over a pending write.
//
//   Ports
//     pixel_clk, rst           sole clock, synchronous active-high reset
//     hcounter, vcounter       raster position from the sync generator
//     wr_req/addr/data, wr_ack host write handshake (ack is a 1-cycle pulse)
//     mem_req/we/addr/wdata    memory request (held while !mem_ready)
//     mem_ready                memory accepts the request this cycle
//     mem_rvalid/rdata         in-order read return, latency >= 1
//     lb_we/bank/addr/data     line-buffer write port (registered)
//     underrun, underrun_clr   sticky late-fetch flag and its clear
//
//   Optional feature macro: ARB_UNDERRUN_EN enables underrun detection.
//   Without it underrun is tied low and underrun_clr is ignored.
module vga_fetch_arbiter #(
  parameter int unsigned HLINES     = 1280,
  parameter int unsigned HMAX       = 1688,
  parameter int unsigned VLINES     = 1024,
  parameter int unsigned VMAX       = 1066,
  parameter int unsigned LINE_WORDS = 40,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FB_BASE    = 0
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic [11:0]       hcounter,
  input  logic [11:0]       vcounter,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic              lb_bank,
  output logic [7:0]        lb_addr,
  output logic [DATA_W-1:0] lb_data,
  output logic              underrun,
  input  logic              underrun_clr
);

  localparam logic [11:0] HLINES_C = 12'(HLINES);
  localparam logic [11:0] HMAX_C   = 12'(HMAX);
  localparam logic [11:0] VLINES_C = 12'(VLINES);
  localparam logic [11:0] VMAX_C   = 12'(VMAX);
  localparam logic [7:0]  LAST_C   = 8'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                fetch_pend_q, fetch_pend_d;
  logic [11:0]         line_q, line_d;
  logic [7:0]          issue_q, issue_d;
  logic [7:0]          ret_q, ret_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                wr_ack_q, wr_ack_d;
  logic                lb_we_q, lb_we_d;
  logic                lb_bank_q, lb_bank_d;
  logic [7:0]          lb_addr_q, lb_addr_d;
  logic [DATA_W-1:0]   lb_data_q, lb_data_d;
  logic                underrun_q, underrun_d;
  logic [11:0]         next_line_s;
  logic                trig_s;

  // Framebuffer word address of (line, word index), truncated to ADDR_W.
  function automatic logic [ADDR_W-1:0] fetch_addr(input logic [11:0] line,
                                                   input logic [7:0]  idx);
    logic [31:0] full;
    full = FB_BASE + (32'(line) * LINE_WORDS) + 32'(idx);
    return full[ADDR_W-1:0];
  endfunction

  assign next_line_s = (vcounter == VMAX_C) ? 12'd0 : vcounter + 12'd1;
  assign trig_s      = (hcounter == HLINES_C) && (next_line_s < VLINES_C);

  // Next-state and registered-output logic for the arbiter FSM.
  always_comb begin
    state_d      = state_q;
    // A trigger only ever sets the single pending flag; IDLE consumes it.
    fetch_pend_d = fetch_pend_q | trig_s;
    line_d       = line_q;
    issue_d      = issue_q;
    ret_d        = ret_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    wr_ack_d     = 1'b0;
    lb_we_d      = 1'b0;
    lb_bank_d    = lb_bank_q;
    lb_addr_d    = lb_addr_q;
    lb_data_d    = lb_data_q;
    unique case (state_q)
      ST_IDLE: begin
        // The live trigger counts as pending so a coincident wr_req loses.
        if (fetch_pend_q || trig_s) begin
          state_d      = ST_FETCH;
          fetch_pend_d = 1'b0;
          line_d       = next_line_s;
          issue_d      = 8'd0;
          ret_d        = 8'd0;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = fetch_addr(next_line_s, 8'd0);
        end else if (wr_req && !wr_ack_q) begin
          // wr_ack_q blocks re-granting the request the host is just dropping.
          state_d     = ST_WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_addr;
          mem_wdata_d = wr_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (mem_req_q && mem_ready) begin
          issue_d = issue_q + 8'd1;
          if (issue_q == LAST_C) begin
            mem_req_d = 1'b0;
          end else begin
            mem_addr_d = fetch_addr(line_q, issue_q + 8'd1);
          end
        end else begin
          issue_d = issue_q;
        end
        if (mem_rvalid) begin
          lb_we_d   = 1'b1;
          lb_data_d = mem_rdata;
          lb_addr_d = ret_q;
          lb_bank_d = line_q[0];
          ret_d     = ret_q + 8'd1;
          if (ret_q == LAST_C) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          ret_d = ret_q;
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          wr_ack_d  = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

`ifdef ARB_UNDERRUN_EN
  // Sticky underrun: a fetch still outstanding at end of line, or a new
  // trigger arriving while the previous burst runs. Set beats clear.
  always_comb begin
    underrun_d = underrun_q;
    if (((hcounter == HMAX_C) && ((state_q == ST_FETCH) || fetch_pend_q)) ||
        (trig_s && (state_q == ST_FETCH))) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end
`else
  logic unused_underrun_clr_s;
  assign unused_underrun_clr_s = underrun_clr;
  assign underrun_d = 1'b0;
`endif

  // State and output registers with synchronous reset.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fetch_pend_q <= 1'b0;
      line_q       <= 12'd0;
      issue_q      <= 8'd0;
      ret_q        <= 8'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wr_ack_q     <= 1'b0;
      lb_we_q      <= 1'b0;
      lb_bank_q    <= 1'b0;
      lb_addr_q    <= 8'd0;
      lb_data_q    <= '0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pend_q <= fetch_pend_d;
      line_q       <= line_d;
      issue_q      <= issue_d;
      ret_q        <= ret_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wr_ack_q     <= wr_ack_d;
      lb_we_q      <= lb_we_d;
      lb_bank_q    <= lb_bank_d;
      lb_addr_q    <= lb_addr_d;
      lb_data_q    <= lb_data_d;
      underrun_q   <= underrun_d;
    end
  end

  assign wr_ack    = wr_ack_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign lb_we     = lb_we_q;
  assign lb_bank   = lb_bank_q;
  assign lb_addr   = lb_addr_q;
  assign lb_data   = lb_data_q;
  assign underrun  = underrun_q;

endmodule
